// File: rtl/computer_run_ctrl.sv
// computer_run_ctrl: run sequencer for the byte computer and its 32x8 memory.
// Loads a program image from a host byte stream, runs the CPU until halt or
// timeout, then streams the whole memory image back to the host.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   go, abort                     start request (IDLE only), sync abort to IDLE
//   in_valid/in_ready/in_data     program load stream
//   out_valid/out_ready/out_data/out_addr  memory dump stream
//   busy, done, timeout           status (done/timeout sticky until next go)
//   cpu_rst_n, cpu_start          CPU control, active only in RUN
//   cpu_halt/we/addr/odata/idata  CPU memory side
//   mem_we/addr/wdata/rdata       shared memory port
module computer_run_ctrl #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          cpu_rst_n,
    output logic          cpu_start,
    input  logic          cpu_halt,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_odata,
    output logic [DW-1:0] cpu_idata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DUMP = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          done_q, done_d, timeout_q, timeout_d;
    wire           last = ptr_q == AW'(DEPTH - 1);
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cyc_d     = cyc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (go) begin
                state_d   = LOAD;
                ptr_d     = '0;
                done_d    = 1'b0;
                timeout_d = 1'b0;
            end
            LOAD: if (in_valid) begin
                ptr_d = ptr_q + 1'b1;
                if (last) begin
                    state_d = RUN;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                // halt wins over a timeout landing in the same cycle
                if (cpu_halt) state_d = DUMP;
                else if (cyc_q == CW'(TIMEOUT - 1)) begin
                    state_d   = DUMP;
                    timeout_d = 1'b1;
                end
            end
            default: if (out_ready) begin
                ptr_d = ptr_q + 1'b1;
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        // abort overrides every transition and leaves the sticky flags alone
        if (abort) begin
            state_d   = IDLE;
            done_d    = done_q;
            timeout_d = timeout_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end
    wire run = state_q == RUN;
    assign busy      = state_q != IDLE;
    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == DUMP;
    assign cpu_rst_n = run;
    assign cpu_start = run;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign mem_we    = run ? cpu_we : in_ready && in_valid;
    assign mem_addr  = run ? cpu_addr : ptr_q;
    assign mem_wdata = run ? cpu_odata : in_data;
    assign out_data  = mem_rdata;
    assign out_addr  = ptr_q;
    assign cpu_idata = mem_rdata;
endmodule

// File: tb/tb_computer_run_ctrl.sv
// tb_computer_run_ctrl: table-driven and randomized bench for computer_run_ctrl.
module tb_computer_run_ctrl;
    localparam int DEPTH = 32, AW = 5, DW = 8, TO = 16;
    logic clk = 0, rst_n = 0, go = 0, abort = 0, in_valid = 0, out_ready = 0;
    logic cpu_halt = 0, cpu_we = 0;
    logic [DW-1:0] in_data = 0, cpu_odata = 0;
    logic [AW-1:0] cpu_addr = 0;
    logic in_ready, out_valid, busy, done, timeout, cpu_rst_n, cpu_start, mem_we;
    logic [DW-1:0] out_data, cpu_idata, mem_wdata, mem_rdata;
    logic [AW-1:0] out_addr, mem_addr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model [DEPTH];
    int errs = 0, checks = 0;

    computer_run_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done), .timeout(timeout),
        .cpu_rst_n(cpu_rst_n), .cpu_start(cpu_start), .cpu_halt(cpu_halt), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_idata(cpu_idata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start();
        go = 1;
        #1 chk("idle_busy", busy, 0);
        @(negedge clk);
        go = 0;
        #1 chk("go_busy", busy, 1);
        chk("go_clears_done", done, 0);
        chk("go_clears_timeout", timeout, 0);
    endtask

    task automatic load(input int vpat, output int cyc);
        int idx = 0;
        cyc = 0;
        while (idx < DEPTH && cyc < 500) begin
            in_valid = vpat == 0 ? 1'b1 : vpat == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            in_data  = model[idx];
            #1 chk("in_ready", in_ready, 1);
            if (in_ready !== 1'b1) break;
            chk("load_cpu_rst_n", cpu_rst_n, 0);
            chk("load_we", mem_we, in_valid);
            if (in_valid) begin
                chk("load_addr", mem_addr, idx);
                chk("load_wdata", mem_wdata, model[idx]);
            end
            @(negedge clk);
            if (in_valid) idx++;
            cyc++;
        end
        in_valid = 0;
        chk("load_count", idx, DEPTH);
    endtask

    task automatic run(input int halt_at, input int wcyc, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, output int k);
        k = 0;
        while (cpu_start === 1'b1 && k < 300) begin
            go        = 1'($urandom_range(0, 1));
            cpu_halt  = k == halt_at;
            cpu_we    = k == wcyc;
            cpu_addr  = cpu_we ? wa : AW'($urandom);
            cpu_odata = wd;
            #1 chk("run_cpu_rst_n", cpu_rst_n, 1);
            chk("run_we", mem_we, cpu_we);
            chk("run_addr", mem_addr, cpu_addr);
            chk("run_idata", cpu_idata, model[cpu_addr]);
            if (cpu_we) model[wa] = wd;
            @(negedge clk);
            k++;
        end
        go = 0; cpu_halt = 0; cpu_we = 0;
    endtask

    task automatic dump(input int rpat, output int n);
        int a = 0;
        n = 0;
        while (a < DEPTH && n < 500) begin
            out_ready = rpat == 0 ? 1'b1 : rpat == 1 ? 1'(n % 3 == 0) : 1'($urandom_range(0, 1));
            #1 chk("out_valid", out_valid, 1);
            if (out_valid !== 1'b1) break;
            chk("out_addr", out_addr, a);
            chk("out_data", out_data, model[a]);
            chk("dump_we", mem_we, 0);
            chk("dump_done_low", done, 0);
            @(negedge clk);
            if (out_ready) a++;
            n++;
        end
        out_ready = 0;
        chk("dump_count", a, DEPTH);
    endtask

    typedef struct {
        bit inc; int vpat; int halt; int wcyc; logic [AW-1:0] wa; logic [DW-1:0] wd;
        int rpat; int exp_run; bit exp_to;
    } vec_t;
    vec_t vt [12];

    initial begin
        int lc, rk, dn;
        vt[0] = '{1, 0, 0, -1, 5'd0, 8'h00, 0, 1, 0};
        vt[1] = '{0, 1, 3, -1, 5'd0, 8'h00, 0, 4, 0};
        vt[2] = '{0, 0, 10, 5, 5'd31, 8'hAA, 0, 11, 0};
        vt[3] = '{0, 0, -1, -1, 5'd0, 8'h00, 0, 16, 1};
        vt[4] = '{0, 0, 15, -1, 5'd0, 8'h00, 0, 16, 0};
        vt[5] = '{0, 0, 2, 7, 5'd4, 8'h5C, 1, 3, 0};
        for (int i = 6; i < 12; i++) begin
            vt[i].inc  = 0;
            vt[i].vpat = 2;
            vt[i].halt = $urandom_range(0, 20);
            vt[i].wcyc = $urandom_range(0, 20);
            vt[i].wa   = AW'($urandom);
            vt[i].wd   = DW'($urandom);
            vt[i].rpat = 2;
            vt[i].exp_run = vt[i].halt < TO ? vt[i].halt + 1 : TO;
            vt[i].exp_to  = vt[i].halt >= TO;
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < DEPTH; i++) model[i] = vt[v].inc ? DW'(i) : DW'($urandom);
            start();
            load(vt[v].vpat, lc);
            if (vt[v].vpat != 2) chk("load_cycles", lc, vt[v].vpat == 1 ? 64 : 32);
            run(vt[v].halt, vt[v].wcyc, vt[v].wa, vt[v].wd, rk);
            chk("run_len", rk, vt[v].exp_run);
            dump(vt[v].rpat, dn);
            if (vt[v].rpat == 0) chk("dump_cycles", dn, 32);
            #1 chk("end_done", done, 1);
            chk("end_timeout", timeout, vt[v].exp_to);
            chk("end_busy", busy, 0);
            @(negedge clk);
        end

        // async reset after the 10th load byte, then a clean restart
        for (int i = 0; i < DEPTH; i++) model[i] = DW'($urandom);
        start();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_data = model[i];
            @(negedge clk);
        end
        #1 rst_n = 0;
        #1 chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_out_addr", out_addr, 0);
        chk("arst_done", done, 0);
        chk("arst_cpu_rst_n", cpu_rst_n, 0);
        @(negedge clk);
        in_valid = 0; rst_n = 1;
        @(negedge clk);
        start();
        load(0, lc);
        run(0, -1, 0, 0, rk);
        chk("arst_run_len", rk, 1);
        dump(0, dn);
        #1 chk("arst_end_done", done, 1);
        @(negedge clk);

        // abort in RUN
        start();
        load(0, lc);
        for (int i = 0; i < 3; i++) begin
            #1 chk("pre_abort_run", cpu_start, 1);
            @(negedge clk);
        end
        abort = 1;
        @(negedge clk);
        abort = 0;
        #1 chk("abort_busy", busy, 0);
        chk("abort_cpu_rst_n", cpu_rst_n, 0);
        chk("abort_cpu_start", cpu_start, 0);
        chk("abort_done", done, 0);
        chk("abort_timeout", timeout, 0);
        @(negedge clk);

        // full run to set done, then abort and go together in IDLE
        start();
        load(0, lc);
        run(4, -1, 0, 0, rk);
        dump(0, dn);
        go = 1; abort = 1;
        @(negedge clk);
        go = 0; abort = 0;
        #1 chk("abort_go_busy", busy, 0);
        chk("abort_go_done", done, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/computer_run_ctrl.md
# computer_run_ctrl

Run sequencer wrapped around the byte computer and its 32x8 memory. On `go` it streams a program image into memory from a host byte stream while holding the CPU in reset. It then releases and starts the CPU, waits for `halt` or a cycle timeout, and streams the final 32-byte memory image back to the host. It owns the memory port mux between the host-side sequencer and the CPU.

## Interface
- `DEPTH`, 32: memory bytes; power of two.
- `AW`, 5: address width, log2(DEPTH).
- `DW`, 8: data width.
- `TIMEOUT`, 255: maximum RUN cycles before forced stop; ≥1.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: start request; honoured only in IDLE.
- `abort` in 1: synchronous; any state → IDLE next edge.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in DW: program load stream.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out DW / `out_addr` out AW: memory dump stream.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: sticky; last run completed dump; cleared on accepted `go`.
- `timeout` out 1: sticky; last run ended by timeout; cleared on accepted `go`.
- `cpu_rst_n` out 1: CPU reset, low except in RUN.
- `cpu_start` out 1: high only in RUN.
- `cpu_halt` in 1, `cpu_we` in 1, `cpu_addr` in AW, `cpu_odata` in DW: CPU memory side.
- `cpu_idata` out DW: read data to CPU.
- `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DW: memory port.
- `mem_rdata` in DW: memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, LOAD, RUN, DUMP. Registers: state, `ptr` (AW), `cyc` (width clog2(TIMEOUT+1)), `done`, `timeout`.
- IDLE: `go` → LOAD; `ptr`=0, `done`=0, `timeout`=0.
- LOAD:
  - `in_ready`=1.
  - On `in_valid&&in_ready`: `mem_we`=1, `mem_addr`=`ptr`, `mem_wdata`=`in_data` in that cycle; `ptr`++.
  - Write at `ptr`=DEPTH-1 → RUN; `ptr` wraps to 0, `cyc`=0.
- RUN:
  - Memory port mux: `mem_we`=`cpu_we`, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_odata`. `cpu_idata`=`mem_rdata` always.
  - `cyc`++ each cycle.
  - `cpu_halt`=1 → DUMP.
  - Otherwise `cyc`==TIMEOUT-1 → DUMP with `timeout`=1. RUN therefore lasts at most TIMEOUT cycles.
  - Halt and timeout in the same cycle: halt wins, `timeout` stays 0.
- DUMP:
  - `mem_we`=0, `mem_addr`=`ptr`, `out_valid`=1, `out_data`=`mem_rdata`, `out_addr`=`ptr`.
  - On `out_valid&&out_ready`: `ptr`++. Accept at DEPTH-1 → IDLE with `done`=1.
- Outside RUN, the mux selects the sequencer. `mem_we`=0 unless stated.
- `abort`: → IDLE next edge; `done`/`timeout` unchanged; memory contents untouched. Takes priority over all transitions.
- `go` outside IDLE: ignored.

## Timing
- Reset values: state IDLE, `ptr`=0, `cyc`=0. Outputs: `busy`=0, `done`=0, `timeout`=0, `in_ready`=0, `out_valid`=0, `out_data`=0-don't-care, `out_addr`=0, `cpu_rst_n`=0, `cpu_start`=0, `mem_we`=0, `mem_addr`=0.
- Reset asserted mid-operation: all of the above take effect immediately, asynchronously.
- `in_ready`, `out_valid`, `cpu_rst_n`, `cpu_start`, `busy` decode from registered state only. `mem_*`/`out_data` are combinational from state, `ptr`, handshakes and CPU inputs.
- Load throughput: 1 byte/cycle. With continuous `in_valid`, LOAD lasts exactly DEPTH cycles.
- First RUN cycle: the edge after the last load write; `cpu_rst_n`=`cpu_start`=1 in that cycle.
- `cpu_halt` is sampled on every RUN cycle, including the first.
- DUMP data stability: `out_data`/`out_addr` hold stable while `out_valid&&!out_ready`.
- Dump throughput: 1 byte/cycle with `out_ready` high. Order is addresses 0..DEPTH-1.
- `done` rises the edge after the final dump accept.

## Test plan
- Continuous load of bytes 0x00..0x1F, CPU model halts in its first RUN cycle, `out_ready`=1 → 32 load cycles; RUN 1 cycle; dump returns `out_addr` i / `out_data` i for i=0..31 in 32 cycles; `done`=1, `timeout`=0.
- Load with `in_valid` low on every other cycle → exactly 32 writes, no write while `in_valid`=0, RUN entered after 64 cycles; memory matches the stream.
- CPU model writes 0xAA to address 31 on RUN cycle 5, then halts on cycle 10 → dump byte 31 = 0xAA, other bytes as loaded, `timeout`=0.
- `TIMEOUT`=16, CPU never halts → `cpu_start` high for exactly 16 cycles, `timeout`=1, full dump follows, `done`=1. Variant with halt on cycle 16 → `timeout`=0.
- `out_ready` driven with pattern 1,0,0,1,… → each byte held stable until accepted; no skipped or duplicated addresses.
- `rst_n` pulsed low after the 10th load byte → outputs immediately at reset values. A subsequent `go` restarts the load at address 0. Separately, `abort` in RUN → IDLE next edge, `cpu_rst_n`=0, `done` unchanged.
